cell_truth_sweeper: RTL and testbench

Exhaustive truth-table sweeper and checker for small combinational standard cells (OAI211_X4 and siblings). It sits directly upstream of the cell under test, driving every input combination in ascending order. It samples the cell output after a programmable settle time and compares each sample against a parameterised expected truth table. It reports pass/fail, the mismatch count and the first failing vector, replacing hand-written per-vector stimulus with one reusable clocked stage.

---
 rtl/cell_truth_sweeper_if.sv | 35 +++
 rtl/cell_truth_sweeper.sv | 156 +++++++++++++++
 tb/tb_cell_truth_sweeper.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cell_truth_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : cell_truth_sweeper_if
// Description : Control, cell-stimulus and result bundle for the truth-table
//               sweeper. The slave side is the sweeper. The master side drives
//               start/abort and returns the output of the cell under test.
// Revision    : 1.0 - initial release
// ============================================================================
interface cell_truth_sweeper_if #(
  parameter int N_IN = 4
) ();

  logic            start;
  logic            abort;
  logic            zn_in;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_idx;

  modport master (
    output start, abort, zn_in,
    input  vec, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );

  modport slave (
    input  start, abort, zn_in,
    output vec, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );

endinterface
`default_nettype wire

// File: rtl/cell_truth_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : cell_truth_sweeper
// Description : Drives every input combination of a small combinational cell
//               in ascending order. Each vector is held for SETTLE_CYCLES
//               before the cell output is sampled once. The sample is compared
//               with the EXPECT truth table, and the block reports pass/fail,
//               the mismatch count and the first failing vector index.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_truth_sweeper #(
  parameter int                    N_IN          = 4,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [(2**N_IN)-1:0]  EXPECT        = 16'h1FFF
) (
  input  wire                  clk,
  input  wire                  rst_n,
  cell_truth_sweeper_if.slave  bus    // interface N_IN must equal this N_IN
);

  localparam logic [7:0] C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_cnt;
  logic [N_IN-1:0] r_vec;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_err_count;
  logic            r_ff_valid;
  logic [N_IN-1:0] r_ff_idx;

  logic            w_start_acc;
  logic            w_abort_acc;
  logic            w_compare;
  logic            w_last_vec;
  logic            w_mismatch;

  assign w_last_vec = &r_vec;
  assign w_mismatch = (bus.zn_in != EXPECT[r_vec]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath strobes. Abort beats the SAMPLE compare.
  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_abort_acc  = 1'b0;
    w_compare    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_acc  = 1'b1;
          w_state_next = S_APPLY;
        end
      end
      S_APPLY: begin
        if (bus.abort) begin
          w_abort_acc  = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == C_SETTLE_LAST) begin
          w_state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          w_abort_acc  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_compare    = 1'b1;
          w_state_next = w_last_vec ? S_DONE : S_APPLY;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Stimulus vector, settle counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 8'd0;
      r_vec       <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_idx    <= '0;
    end else begin
      // The done pulse appears on the edge that leaves DONE.
      r_done <= (r_state == S_DONE);

      if (w_start_acc) begin
        r_vec       <= '0;
        r_cnt       <= 8'd0;
        r_err_count <= '0;
        r_pass      <= 1'b0;
        r_ff_valid  <= 1'b0;
        r_ff_idx    <= '0;
      end else if (w_abort_acc) begin
        // Partial error count and first-fail info are kept for debug.
        r_vec  <= '0;
        r_cnt  <= 8'd0;
        r_pass <= 1'b0;
      end else if (r_state == S_APPLY) begin
        r_cnt <= r_cnt + 8'd1;
      end else if (w_compare) begin
        if (w_mismatch) begin
          r_err_count <= r_err_count + 1'b1;
          if (!r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_idx   <= r_vec;
          end
        end
        // The last vector stays on the pins until the sweep closes, so vec
        // never wraps inside a sweep.
        if (!w_last_vec) begin
          r_vec <= r_vec + 1'b1;
          r_cnt <= 8'd0;
        end
      end else if (r_state == S_DONE) begin
        // err_count already includes the final SAMPLE result here.
        r_pass <= (r_err_count == '0);
        r_vec  <= '0;
      end
    end
  end

  assign bus.vec              = r_vec;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_count        = r_err_count;
  assign bus.first_fail_valid = r_ff_valid;
  assign bus.first_fail_idx   = r_ff_idx;

endmodule
`default_nettype wire

// File: tb/tb_cell_truth_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_truth_sweeper
// Description : Self-checking bench for cell_truth_sweeper with default
//               parameters. It uses an OAI211 reference model and variants on
//               zn_in, and a scoreboard of expected sweep results popped on
//               done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_truth_sweeper;

  typedef struct {
    int mode;      // 0 good OAI211, 1 row 1111 forced to 1, 2 tied 1, 3 tied 0
    int err;
    int ffi;
    int ffv;
    int pass;
    int done_cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   mode = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  rec_t sb[$];
  rec_t tbl[4];

  cell_truth_sweeper_if #(.N_IN(4)) bus ();

  cell_truth_sweeper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count rising edges so each check can be placed relative to the start edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference cell: vec[3]=A, vec[2]=B, vec[1]=C1, vec[0]=C2.
  always_comb begin
    logic good;
    good = !((bus.vec[1] | bus.vec[0]) & bus.vec[3] & bus.vec[2]);
    case (mode)
      0:       bus.zn_in = good;
      1:       bus.zn_in = (bus.vec == 4'hF) ? 1'b1 : good;
      2:       bus.zn_in = 1'b1;
      default: bus.zn_in = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pop the scoreboard when done appears. A done with nothing pending is an error.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("err_count", int'(bus.err_count), e.err);
          chk("first_fail_idx", int'(bus.first_fail_idx), e.ffi);
          chk("first_fail_valid", int'(bus.first_fail_valid), e.ffv);
          chk("pass", int'(bus.pass), e.pass);
        end
      end
    end
  end

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_vec"}, int'(bus.vec), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_pass"}, int'(bus.pass), 0);
    chk({tag, "_err"}, int'(bus.err_count), 0);
    chk({tag, "_ffv"}, int'(bus.first_fail_valid), 0);
    chk({tag, "_ffi"}, int'(bus.first_fail_idx), 0);
  endtask

  // Start a sweep and follow it cycle by cycle. Result values are checked by
  // the scoreboard monitor.
  task automatic run_sweep(input rec_t r);
    int e0;
    int t;
    rec_t e;
    e = r;
    mode = r.mode;
    @(negedge clk);
    bus.start = 1'b1;
    e0 = cyc + 1;
    e.done_cyc = e0 + 49;
    sb.push_back(e);
    for (int i = 0; i <= 50; i++) begin
      @(posedge clk);
      #1;
      t = cyc - e0;
      if (t == 0) bus.start = 1'b0;
      if (t < 48) begin
        chk("sweep_vec", int'(bus.vec), t / 3);
        chk("sweep_busy", int'(bus.busy), 1);
      end else if (t == 48) begin
        chk("done_early", int'(bus.done), 0);
        chk("busy_in_done", int'(bus.busy), 1);
      end else if (t == 49) begin
        chk("busy_fall", int'(bus.busy), 0);
        chk("done_pulse", int'(bus.done), 1);
      end else begin
        chk("done_width", int'(bus.done), 0);
        chk("vec_after", int'(bus.vec), 0);
      end
    end
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  // Abort at relative cycle t_ab. The abort is sampled on the next edge.
  task automatic abort_at(input int t_ab, input int exp_err);
    int e0;
    mode = 3;
    @(negedge clk);
    bus.start = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i <= t_ab; i++) begin
      @(posedge clk);
      #1;
      if (cyc == e0) bus.start = 1'b0;
    end
    chk("pre_abort_vec", int'(bus.vec), 6);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_vec", int'(bus.vec), 0);
    chk("abort_pass", int'(bus.pass), 0);
    chk("abort_err", int'(bus.err_count), exp_err);
    chk("abort_ffv", int'(bus.first_fail_valid), 1);
    chk("abort_ffi", int'(bus.first_fail_idx), 0);
    repeat (55) @(posedge clk);
    #1;
    chk("abort_idle", int'(bus.busy), 0);
  endtask

  initial begin
    int e0;
    int t;
    rec_t e;

    tbl[0] = '{mode: 0, err: 0,  ffi: 0,  ffv: 0, pass: 1, done_cyc: 0};
    tbl[1] = '{mode: 1, err: 1,  ffi: 15, ffv: 1, pass: 0, done_cyc: 0};
    tbl[2] = '{mode: 2, err: 3,  ffi: 13, ffv: 1, pass: 0, done_cyc: 0};
    tbl[3] = '{mode: 3, err: 13, ffi: 0,  ffv: 1, pass: 0, done_cyc: 0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_sweep(tbl[i]);

    // Abort in APPLY with vec=6. Vectors 0..5 have already mismatched.
    abort_at(18, 6);
    // Abort in the SAMPLE cycle of vec=6. That compare must be discarded.
    abort_at(20, 6);
    run_sweep(tbl[0]);

    // Hold start for 60 cycles. The second sweep begins right after done and
    // clears the first sweep's results.
    mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    e0 = cyc + 1;
    e = tbl[2];
    e.done_cyc = e0 + 49;
    sb.push_back(e);
    for (int i = 0; i <= 101; i++) begin
      @(posedge clk);
      #1;
      t = cyc - e0;
      if (t == 59) bus.start = 1'b0;
      if (t == 49) chk("held_busy_gap", int'(bus.busy), 0);
      if (t == 50) begin
        chk("held_restart_busy", int'(bus.busy), 1);
        chk("held_clear_err", int'(bus.err_count), 0);
        chk("held_clear_ffv", int'(bus.first_fail_valid), 0);
        chk("held_clear_ffi", int'(bus.first_fail_idx), 0);
        mode = 0;
        e = tbl[0];
        e.done_cyc = e0 + 50 + 49;
        sb.push_back(e);
      end
      if (t == 101) chk("held_sb_drained", sb.size(), 0);
    end
    sb.delete();

    // Assert an asynchronous reset between clock edges in the middle of a sweep.
    mode = 3;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (55) @(posedge clk);
    #1;
    chk("post_rst_idle", int'(bus.busy), 0);

    run_sweep(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
